fpu_dp_subtractor: RTL and testbench

FPU_DP_SUBTRACTOR -- requirements
Module: fpu_dp_subtractor

---
 rtl/fpu_dp_subtractor.sv | 151 +++++++++++++++
 tb/tb_fpu_dp_subtractor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fpu_dp_subtractor.sv
// fpu_dp_subtractor: IEEE-754 binary64 subtractor (a - b), round toward zero.
// Three-stage pipeline: align, add/subtract, normalize. Denormal inputs are
// flushed to zero, underflowing results are flushed to zero, and overflowing
// results saturate to signed infinity.
module fpu_dp_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        out_valid,
  input  logic        out_ready
);

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !rst_n || !stall;

  // ---------------------------------------------------------------------------
  // S1: flush denormals, order by magnitude, align the smaller operand
  // ---------------------------------------------------------------------------
  logic [10:0]  ea, eb, ex, ey, d;
  logic [52:0]  ma, mb, mx, my;
  logic         swap, sx, sy;
  logic [111:0] sh;
  logic [55:0]  y_al;

  // Operand swap and right shift with guard/round/sticky.
  always_comb begin
    ea   = a[62:52];
    eb   = b[62:52];
    ma   = (ea == '0) ? '0 : {1'b1, a[51:0]};
    mb   = (eb == '0) ? '0 : {1'b1, b[51:0]};
    swap = {eb, mb} > {ea, ma};
    if (swap) begin
      ex = eb;  mx = mb;  sx = ~b[63];
      ey = ea;  my = ma;  sy = a[63];
    end else begin
      ex = ea;  mx = ma;  sx = a[63];
      ey = eb;  my = mb;  sy = ~b[63];
    end
    d  = ex - ey;
    sh = {my, 59'd0} >> d;
    // Bits shifted past the round position collapse into the sticky LSB so
    // a subtract borrows correctly for truncation.
    if (d > 11'd55)
      y_al = {55'd0, |my};
    else
      y_al = {sh[111:57], sh[56] | (|sh[55:0])};
  end

  logic        s1_valid;
  logic        s1_sign;
  logic        s1_sub;
  logic [10:0] s1_exp;
  logic [55:0] s1_x;
  logic [55:0] s1_y;

  // S1 register: aligned operands of an accepted input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= sx;
        s1_sub  <= sx ^ sy;
        s1_exp  <= ex;
        s1_x    <= {mx, 3'b000};
        s1_y    <= y_al;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: magnitude add or subtract (larger minus smaller never goes negative)
  // ---------------------------------------------------------------------------
  logic        s2_valid;
  logic        s2_sign;
  logic [10:0] s2_exp;
  logic [56:0] s2_sum;

  // S2 register: raw magnitude sum/difference with carry bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_exp  <= s1_exp;
        s2_sum  <= s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y})
                          : ({1'b0, s1_x} + {1'b0, s1_y});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: leading-one detect, normalize, exponent adjust, flags
  // ---------------------------------------------------------------------------
  logic [5:0]  lead;
  logic        nz;
  logic [12:0] e_adj;
  logic [51:0] frac;
  logic        ov_n, uf_n;
  logic [63:0] res_n;

  // Hidden bit sits at bit 55 of the sum; exponent shifts by (lead - 55).
  always_comb begin
    lead = '0;
    for (int unsigned i = 0; i < 57; i++) begin
      if (s2_sum[i]) lead = 6'(i);
    end
    nz    = |s2_sum;
    e_adj = {2'b00, s2_exp} + {7'd0, lead} - 13'd55;
    frac  = 52'((s2_sum << (6'd56 - lead)) >> 4);
    uf_n  = nz && (e_adj[12] || (e_adj == '0));
    ov_n  = nz && !e_adj[12] && (e_adj > 13'd2046);
    if (!nz || uf_n)
      res_n = '0;
    else if (ov_n)
      res_n = {s2_sign, 11'h7FF, 52'd0};
    else
      res_n = {s2_sign, e_adj[10:0], frac};
  end

  // S3 register: the visible output stage, held while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result    <= res_n;
        overflow  <= ov_n;
        underflow <= uf_n;
      end
    end
  end

endmodule

// File: tb/tb_fpu_dp_subtractor.sv
// Testbench for fpu_dp_subtractor: constant vector table streamed through a
// scoreboard, plus backpressure and mid-operation reset sequences.
module tb_fpu_dp_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  fpu_dp_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        ov;
    logic        uf;
  } vec_t;

  typedef struct {
    logic [63:0] res;
    logic        ov;
    logic        uf;
    int          acc;
    bit          lat;
  } exp_t;

  vec_t vt [14];
  exp_t sb [$];
  exp_t mon_e;
  vec_t cur;
  bit   cur_lat;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_out = 0;
  int   snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
  endtask

  // Output monitor first, then record any input accepted at the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        n_out++;
        check("output_expected", 66'(sb.size() != 0), 66'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("result", {result, overflow, underflow}, {mon_e.res, mon_e.ov, mon_e.uf});
          if (mon_e.lat) check("latency", 66'(cyc - mon_e.acc), 66'd3);
        end
        check("flags_exclusive", 66'(overflow && underflow), 66'd0);
      end
      if (in_valid && in_ready)
        sb.push_back('{cur.res, cur.ov, cur.uf, cyc, cur_lat});
    end
  end

  task automatic send(input vec_t v, input bit lat);
    @(posedge clk); #1;
    a        = v.a;
    b        = v.b;
    cur      = v;
    cur_lat  = lat;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) return;
    end
    check("in_ready_timeout", 66'(in_ready), 66'd1);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = {$urandom, $urandom};
    b        = {$urandom, $urandom};
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(negedge clk); #1;
    end
    check(name, 66'(sb.size()), 66'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{64'h4008000000000000, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 1'b0};
    vt[1]  = '{64'h3FF0000000000000, 64'hBFF0000000000000, 64'h4000000000000000, 1'b0, 1'b0};
    vt[2]  = '{64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 1'b0, 1'b0};
    vt[3]  = '{64'h3FF0000000000000, 64'h4000000000000000, 64'hBFF0000000000000, 1'b0, 1'b0};
    vt[4]  = '{64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, 1'b0};
    vt[5]  = '{64'h0010000000000001, 64'h0010000000000000, 64'h0000000000000000, 1'b0, 1'b1};
    vt[6]  = '{64'h4340000000000000, 64'h3FF0000000000000, 64'h433FFFFFFFFFFFFF, 1'b0, 1'b0};
    vt[7]  = '{64'h4000000000000000, 64'h3FE0000000000000, 64'h3FF8000000000000, 1'b0, 1'b0};
    vt[8]  = '{64'h3FF0000000000000, 64'h3C30000000000000, 64'h3FEFFFFFFFFFFFFF, 1'b0, 1'b0};
    vt[9]  = '{64'h3FF0000000000000, 64'hBC30000000000000, 64'h3FF0000000000000, 1'b0, 1'b0};
    vt[10] = '{64'h0000000000000001, 64'h3FF0000000000000, 64'hBFF0000000000000, 1'b0, 1'b0};
    vt[11] = '{64'hC008000000000000, 64'hBFF0000000000000, 64'hC000000000000000, 1'b0, 1'b0};
    vt[12] = '{64'hFFEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 64'hFFF0000000000000, 1'b1, 1'b0};
    vt[13] = '{64'h0000000000000000, 64'h8000000000000000, 64'h0000000000000000, 1'b0, 1'b0};

    // Reset with a valid input presented: nothing may be accepted.
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    a         = 64'h4008000000000000;
    b         = 64'h3FF0000000000000;
    out_ready = 1'b1;
    cur       = vt[0];
    cur_lat   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 66'(out_valid), 66'd0);
    check("reset_result", 66'(result), 66'd0);
    check("reset_overflow", 66'(overflow), 66'd0);
    check("reset_underflow", 66'(underflow), 66'd0);
    check("reset_in_ready", 66'(in_ready), 66'd1);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("no_output_after_reset", 66'(n_out), 66'd0);

    // Vector table streamed back-to-back, 3-cycle latency checked per result.
    for (int i = 0; i < 14; i++) send(vt[i], 1'b1);
    idle();
    drain("table_drain");

    // Backpressure: six ops with out_ready low for five cycles mid-stream.
    snap = n_out;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vt[i + 1], 1'b0);
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_out_valid", 66'(out_valid), 66'd1);
          check("stall_in_ready", 66'(in_ready), 66'd0);
          check("stall_pending", 66'(sb.size() != 0), 66'd1);
          if (sb.size() != 0)
            check("stall_hold", {result, overflow, underflow}, {sb[0].res, sb[0].ov, sb[0].uf});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("bp_drain");
    check("bp_count", 66'(n_out - snap), 66'd6);

    // Mid-operation reset: two in-flight ops are discarded.
    snap = n_out;
    send(vt[0], 1'b1);
    send(vt[6], 1'b1);
    @(posedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", 66'(out_valid), 66'd0);
    #1;
    check("midrst_no_output", 66'(n_out - snap), 66'd0);
    send(vt[7], 1'b1);
    idle();
    repeat (8) @(negedge clk);
    #1;
    check("midrst_one_result", 66'(n_out - snap), 66'd1);
    check("midrst_queue_empty", 66'(sb.size()), 66'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
